// File: rtl/jtag_dbg_mailbox_dr.sv
// JTAG debug data register bridging TAP DR shifts to a system mailbox:
// a valid/ready write channel out and a single-entry read buffer in.
module jtag_dbg_mailbox_dr #(
  parameter int DATA_W = 32
) (
  input  logic              tck_pad_i,
  input  logic              trst_pad_i,
  input  logic              debug_select_i,
  input  logic              capture_dr_i,
  input  logic              shift_dr_i,
  input  logic              update_dr_i,
  input  logic              tdi_pad_i,
  output logic              debug_tdo_o,
  output logic              wr_valid_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic              wr_ready_i,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              rd_ready_o,
  output logic              overflow_o
);

  localparam int DR_W = DATA_W + 2;

  logic [DR_W-1:0]   sr_r;
  logic              rd_full_r;
  logic [DATA_W-1:0] rd_buf_r;

  logic cap_s;
  logic shift_s;
  logic upd_s;
  logic wr_req_s;
  logic clr_ovf_s;
  logic slot_free_s;
  logic wr_accept_s;
  logic wr_drop_s;
  logic push_s;

  // Strobe priority (capture > shift > update) and update decode
  always_comb begin
    cap_s       = debug_select_i & capture_dr_i;
    shift_s     = debug_select_i & shift_dr_i & ~capture_dr_i;
    upd_s       = debug_select_i & update_dr_i & ~capture_dr_i & ~shift_dr_i;
    wr_req_s    = sr_r[DR_W-1];
    clr_ovf_s   = sr_r[DATA_W];
    slot_free_s = ~wr_valid_o | wr_ready_i;
    wr_accept_s = upd_s & wr_req_s & slot_free_s;
    wr_drop_s   = upd_s & wr_req_s & ~slot_free_s;
    push_s      = rd_valid_i & rd_ready_o;
  end

  // Read buffer stays closed to the system while reset is held
  assign rd_ready_o  = ~trst_pad_i & ~rd_full_r;
  assign debug_tdo_o = sr_r[0];

  // Shift register, write channel, overflow flag and read buffer
  always_ff @(posedge tck_pad_i) begin
    if (trst_pad_i) begin
      sr_r       <= '0;
      wr_valid_o <= 1'b0;
      wr_data_o  <= '0;
      rd_full_r  <= 1'b0;
      rd_buf_r   <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (cap_s) begin
        sr_r <= {overflow_o, rd_full_r, rd_buf_r};
      end else if (shift_s) begin
        sr_r <= {tdi_pad_i, sr_r[DR_W-1:1]};
      end else begin
        sr_r <= sr_r;
      end

      if (wr_accept_s) begin
        wr_valid_o <= 1'b1;
        wr_data_o  <= sr_r[DATA_W-1:0];
      end else if (wr_valid_o & wr_ready_i) begin
        wr_valid_o <= 1'b0;
      end else begin
        wr_valid_o <= wr_valid_o;
      end

      // A dropped write sets the flag even if the same update asks to clear it
      if (wr_drop_s) begin
        overflow_o <= 1'b1;
      end else if (upd_s & clr_ovf_s) begin
        overflow_o <= 1'b0;
      end else begin
        overflow_o <= overflow_o;
      end

      // Push only happens when empty, so it never collides with the consume
      if (push_s) begin
        rd_buf_r  <= rd_data_i;
        rd_full_r <= 1'b1;
      end else if (cap_s) begin
        rd_full_r <= 1'b0;
      end else begin
        rd_full_r <= rd_full_r;
      end
    end
  end

endmodule

// File: doc/jtag_dbg_mailbox_dr.md
Name: jtag_dbg_mailbox_dr

Overview:
- Debug data register that sits directly downstream of the TAP controller.
- Consumes the TAP's debug_select / capture_dr / shift_dr / update_dr strobes and TDI.
- Returns its serial output to the TAP's debug_tdi_i input.
- Bridges JTAG shifts to a system-side mailbox: one write channel (JTAG to system, valid/ready) and one single-entry read buffer (system to JTAG).
- Single clock domain: everything runs on TCK.

Parameters:
- DATA_W, 32, mailbox payload width.
- DR_W, DATA_W+2, shift register length (derived; not overridden).

Ports:
- tck_pad_i  in  1  JTAG clock; all state updates on rising edge.
- trst_pad_i  in  1  reset, synchronous, active-high.
- debug_select_i  in  1  TAP debug instruction selected; gates all DR actions.
- capture_dr_i  in  1  TAP Capture-DR state.
- shift_dr_i  in  1  TAP Shift-DR state.
- update_dr_i  in  1  TAP Update-DR state.
- tdi_pad_i  in  1  serial input.
- debug_tdo_o  out  1  serial output to the TAP's debug_tdi_i.
- wr_valid_o  out  1  write word pending to system.
- wr_data_o  out  DATA_W  write word.
- wr_ready_i  in  1  system accepts the write word.
- rd_valid_i  in  1  system offers a read word.
- rd_data_i  in  DATA_W  read word.
- rd_ready_o  out  1  read buffer empty, can accept.
- overflow_o  out  1  sticky: a write update was dropped.

Behaviour:
- Reset (trst_pad_i=1 at clock edge): sr=0, debug_tdo_o=0, wr_valid_o=0, wr_data_o=0, rd_full=0, rd_buf=0, overflow_o=0. rd_ready_o=0 while trst_pad_i is high; otherwise rd_ready_o=!rd_full.
- Reset mid-shift or mid-handshake aborts the operation. A pending write is discarded; no partial state survives.
- DR actions occur only when debug_select_i=1. If several strobes are high together: capture > shift > update; only the winner acts.
- debug_tdo_o = sr[0] (direct from register, no extra stage).
- Capture:
  - sr <= {overflow_o, rd_full, rd_buf}; bit DR_W-1 is overflow, bit DATA_W is rd_full.
  - If rd_full=1, the buffer is consumed: rd_full<=0 (rd_buf holds its value).
- Shift: sr <= {tdi_pad_i, sr[DR_W-1:1]}; LSB first out, first-shifted TDI bit ends at sr[0] after DR_W shifts. Pause (no strobe) holds sr.
- Update: decode sr[DR_W-1]=WR_REQ, sr[DATA_W]=CLR_OVF, sr[DATA_W-1:0]=payload.
  - WR_REQ=1 and slot free: wr_data_o<=payload, wr_valid_o<=1, next cycle. Slot free means wr_valid_o=0, or wr_valid_o&wr_ready_i in the same cycle.
  - WR_REQ=1 and slot busy: payload dropped; wr_data_o unchanged; overflow_o<=1.
  - CLR_OVF=1 clears overflow_o. A set in the same update wins over the clear.
  - WR_REQ=0: no write; CLR_OVF still honoured.
- Write handshake:
  - wr_valid_o stays high, with wr_data_o stable, until a cycle with wr_ready_i=1; wr_valid_o clears on the next edge.
  - wr_ready_i is ignored when wr_valid_o=0.
- Read buffer:
  - On rd_valid_i & rd_ready_o: rd_buf<=rd_data_i, rd_full<=1.
  - Capture and push in the same cycle with buffer empty: capture sees empty (rd_full=0 field); pushed word lands in rd_buf. No loss.
  - Buffer full: rd_ready_o=0; system holds its word.
- Latency: capture-to-first-bit on TDO is 1 edge. Update-to-wr_valid_o is 1 edge.

Test Plan:
- Reset check: assert trst_pad_i 2 cycles -> all outputs 0, including rd_ready_o. Release -> rd_ready_o=1 next cycle.
- Read path: push rd_data_i=32'hDEADBEEF, then capture, then 34 shifts. TDO LSB-first shows 0xDEADBEEF, then bit32=1 (rd_full), then bit33=0 (overflow). rd_ready_o returns to 1 the cycle after capture.
- Write path: shift in {WR_REQ=1, CLR=0, 32'h12345678}, then update -> wr_valid_o=1, wr_data_o=0x12345678 next cycle. Hold wr_ready_i=0 for 5 cycles -> values stable. wr_ready_i=1 -> wr_valid_o=0 next cycle.
- Overflow: while wr_valid_o=1 and wr_ready_i=0, update with 32'hCAFE0000 -> wr_data_o stays 0x12345678, overflow_o=1. Update with CLR_OVF=1, WR_REQ=0 -> overflow_o=0.
- Gating and priority: debug_select_i=0 with shift/update strobes -> sr, wr_valid_o unchanged. capture_dr_i and shift_dr_i both high -> capture value loaded, no shift.
- Empty capture race: rd buffer empty, rd_valid_i=1 with 32'hA5A5A5A5 in the same cycle as capture -> shifted rd_full bit=0; next capture returns 0xA5A5A5A5 with rd_full=1.
